// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 bus: word RAM plus console MMIO (KBSR/KBDR over an RX FIFO, DSR/DDR to a TX handshake).
// Optional LC3_MEM_OOR_FAULT_EN: unmapped addresses read 16'hDEAD, drop writes and set a sticky fault.
module lc3_mem_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RX_DEPTH  = 4,
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter logic [15:0] DSR_ADDR  = 16'hFE04,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        writeEnable,
  input  logic [15:0] address,
  input  logic [15:0] dataToMemory,
  output logic [15:0] dataFromMemory,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        fault
);

  localparam int unsigned PTR_W     = $clog2(RX_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned RAM_WORDS = 1 << ADDR_W;

  logic [15:0]       ram [RAM_WORDS];
  logic [7:0]        rx_buf [RX_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [15:0]       prev_addr;
  logic              prev_rd;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              is_mmio;
  logic              ram_we;
  logic              ddr_we;
  logic [ADDR_W-1:0] ram_idx;

  assign ram_idx = address[ADDR_W-1:0];
  assign is_mmio = (address == KBSR_ADDR) || (address == KBDR_ADDR) ||
                   (address == DSR_ADDR)  || (address == DDR_ADDR);

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(RX_DEPTH));
  assign rx_ready = ~full;
  assign push     = rx_valid & ~full;
  // Pop only once the core has moved off KBDR, so KBDR data holds for the whole read
  assign pop      = prev_rd & (prev_addr == KBDR_ADDR) & (address != KBDR_ADDR) & ~empty;
  assign ddr_we   = writeEnable & (address == DDR_ADDR);

`ifdef LC3_MEM_OOR_FAULT_EN
  logic is_ram;
  assign is_ram = ((address >> ADDR_W) == 16'h0000);
  assign ram_we = writeEnable & is_ram;
`else
  assign ram_we = writeEnable & ~is_mmio;
`endif

  // Zero-latency read mux
  always_comb begin
    dataFromMemory = ram[ram_idx];
    if (address == KBSR_ADDR) begin
      dataFromMemory = {~empty, 15'b0};
    end else if (address == KBDR_ADDR) begin
      dataFromMemory = empty ? 16'h0000 : {8'h00, rx_buf[head]};
    end else if (address == DSR_ADDR) begin
      dataFromMemory = {~tx_valid, 15'b0};
    end else if (address == DDR_ADDR) begin
      dataFromMemory = 16'h0000;
    end
`ifdef LC3_MEM_OOR_FAULT_EN
    else if (!is_ram) begin
      dataFromMemory = 16'hDEAD;
    end
`endif
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= dataToMemory;
  end

  always_ff @(posedge clk) begin
    if (push) rx_buf[tail] <= rx_data;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // TX byte: a DDR write landing while busy (including the handshake cycle) is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end else if (!tx_valid && ddr_we) begin
      tx_valid <= 1'b1;
      tx_data  <= dataToMemory[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_addr <= 16'h0000;
      prev_rd   <= 1'b0;
    end else begin
      prev_addr <= address;
      prev_rd   <= ~writeEnable;
    end
  end

`ifdef LC3_MEM_OOR_FAULT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault <= 1'b0;
    end else if (!is_ram && !is_mmio) begin
      fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: a queue/array reference model predicts each cycle's outputs,
// a negedge monitor pops and compares them.
module tb_lc3_mem_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WORDS  = 1024;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NRAND  = 3000;
  localparam int unsigned NDIR   = 41;
  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR  = 16'hFE06;

  logic        clk;
  logic        reset;
  logic        writeEnable;
  logic [15:0] address;
  logic [15:0] dataToMemory;
  logic [15:0] dataFromMemory;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        fault;

  lc3_mem_responder dut (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .address(address),
    .dataToMemory(dataToMemory), .dataFromMemory(dataFromMemory),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk_rd;
    logic [15:0] addr;
    logic [15:0] rd;
    logic        rxr;
    logic        txv;
    logic [7:0]  txd;
    logic        flt;
  } exp_t;

  exp_t expq[$];
  int   checks;
  int   errors;

  // Reference model state
  logic [15:0] ram_m [WORDS];
  bit          known [WORDS];
  logic [7:0]  fifo_m[$];
  bit          tx_pend;
  logic [7:0]  tx_byte;
  bit          flt_m;
  logic [15:0] m_prev_addr;
  bit          m_prev_rd;
  bit          holding;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic bit is_mmio(input logic [15:0] a);
    return (a == KBSR) || (a == KBDR) || (a == DSR) || (a == DDR);
  endfunction

  function automatic bit in_ram(input logic [15:0] a);
    return 32'(a) < WORDS;
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    tx_pend     = 1'b0;
    tx_byte     = 8'h00;
    flt_m       = 1'b0;
    m_prev_addr = 16'h0000;
    m_prev_rd   = 1'b0;
    holding     = 1'b0;
  endtask

  // Apply one rising edge using the inputs that were held across it
  task automatic model_edge();
    int sz;
    bit take;
    bit drop;
    logic [ADDR_W-1:0] idx;
    sz   = fifo_m.size();
    take = rx_valid && (sz < DEPTH);
    drop = m_prev_rd && (m_prev_addr == KBDR) && (address != KBDR) && (sz > 0);
    if (drop) void'(fifo_m.pop_front());
    if (take) fifo_m.push_back(rx_data);
    holding = rx_valid && !take;
    idx = address[ADDR_W-1:0];
    if (writeEnable) begin
`ifdef LC3_MEM_OOR_FAULT_EN
      if (in_ram(address)) begin
`else
      if (!is_mmio(address)) begin
`endif
        ram_m[idx] = dataToMemory;
        known[idx] = 1'b1;
      end
    end
    if (tx_pend && tx_ready) tx_pend = 1'b0;
    else if (!tx_pend && writeEnable && address == DDR) begin
      tx_pend = 1'b1;
      tx_byte = dataToMemory[7:0];
    end
`ifdef LC3_MEM_OOR_FAULT_EN
    if (!in_ram(address) && !is_mmio(address)) flt_m = 1'b1;
`endif
    m_prev_addr = address;
    m_prev_rd   = !writeEnable;
  endtask

  task automatic push_expect();
    exp_t e;
    logic [ADDR_W-1:0] idx;
    idx      = address[ADDR_W-1:0];
    e.addr   = address;
    e.chk_rd = 1'b1;
    e.rd     = 16'h0000;
    if (address == KBSR)      e.rd = (fifo_m.size() > 0) ? 16'h8000 : 16'h0000;
    else if (address == KBDR) e.rd = (fifo_m.size() > 0) ? {8'h00, fifo_m[0]} : 16'h0000;
    else if (address == DSR)  e.rd = tx_pend ? 16'h0000 : 16'h8000;
    else if (address == DDR)  e.rd = 16'h0000;
`ifdef LC3_MEM_OOR_FAULT_EN
    else if (!in_ram(address)) e.rd = 16'hDEAD;
`endif
    else begin
      e.rd     = ram_m[idx];
      e.chk_rd = known[idx];
    end
    e.rxr = fifo_m.size() < DEPTH;
    e.txv = tx_pend;
    e.txd = tx_byte;
    e.flt = flt_m;
    expq.push_back(e);
  endtask

  // Choose the inputs for the next cycle; a refused RX byte is always re-offered unchanged
  task automatic choose(input int c);
    bit prev_we;
    int s;
    prev_we      = writeEnable;
    writeEnable  = 1'b0;
    tx_ready     = 1'b0;
    dataToMemory = 16'($urandom);
    if (!holding) rx_valid = 1'b0;
    if (c < int'(WORDS)) begin
      address     = 16'(c);
      writeEnable = 1'b1;
    end else if (c < int'(WORDS + NRAND)) begin
      if ($urandom_range(9) >= 3) begin
        case ($urandom_range(2))
          0:       address = 16'($urandom_range(WORDS - 1));
          1:       address = KBSR + 16'(2 * $urandom_range(3));
          default: address = 16'($urandom_range(16'hFFFF, WORDS));
        endcase
      end
      writeEnable = !prev_we && ($urandom_range(4) == 0);
      tx_ready    = ($urandom_range(2) == 0);
      if (!holding) begin
        rx_valid = 1'($urandom_range(1));
        rx_data  = 8'($urandom);
      end
    end else begin
      s = c - int'(WORDS + NRAND);
      if (s < 6) begin
        address = 16'h0001;
        if (!holding) begin
          rx_valid = 1'b1;
          rx_data  = 8'($urandom);
        end
      end else if (s < 26) begin
        address  = (s % 2 == 0) ? KBDR : 16'h0001;
        tx_ready = 1'b1;
      end else if (s == 26 || s == 28) begin
        address      = DDR;
        writeEnable  = 1'b1;
        dataToMemory = (s == 26) ? 16'h0057 : 16'h0099;
      end else if (s == 27) begin
        address = DSR;
      end else if (s < 32) begin
        address = 16'h0001;
        if (!holding) begin
          rx_valid = 1'b1;
          rx_data  = 8'($urandom);
        end
      end else if (s == 32) begin
        address = KBSR;
      end else begin
        address = (s % 2 == 0) ? DSR : KBSR;
      end
    end
  endtask

  // Monitor: compare DUT outputs against the oldest prediction, mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.chk_rd) chk($sformatf("read@%h", e.addr), dataFromMemory, e.rd);
        chk("rx_ready", 16'(rx_ready), 16'(e.rxr));
        chk("tx_valid", 16'(tx_valid), 16'(e.txv));
        chk("tx_data",  16'(tx_data),  16'(e.txd));
        chk("fault",    16'(fault),    16'(e.flt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < int'(WORDS); i++) known[i] = 1'b0;
    model_reset();
    reset        = 1'b0;
    writeEnable  = 1'b0;
    address      = KBSR;
    dataToMemory = 16'h0000;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    tx_ready     = 1'b0;
    #1 push_expect();
    #11 reset = 1'b1;
    for (int c = 0; c < int'(WORDS + NRAND + NDIR); c++) begin
      @(posedge clk);
      #1;
      model_edge();
      choose(c);
      push_expect();
      if (c == int'(WORDS + NRAND) + 32) begin
        #1 reset = 1'b0;
        #1;
        chk("rst_tx_valid", 16'(tx_valid), 16'h0000);
        chk("rst_tx_data",  16'(tx_data),  16'h0000);
        chk("rst_rx_ready", 16'(rx_ready), 16'h0001);
        chk("rst_kbsr",     dataFromMemory, 16'h0000);
        chk("rst_fault",    16'(fault),    16'h0000);
        model_reset();
        #1 reset = 1'b1;
        expq.delete();
        push_expect();
      end
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
